// File: rtl/noc_pkg.sv
// noc_pkg -- packet layout shared by the pi_switch tree and its leaf injectors.
//
// A packet is {valid, dest_addr, payload} with the payload in the LSBs.
// The helpers below give the bit positions for a given address width
// (a_sz) and payload width (payload_sz), so that every block slices the
// packet the same way.
package noc_pkg;

    localparam int unsigned inj_cnt_w   = 16;
    localparam logic [15:0] inj_cnt_max = 16'hFFFF;

    function automatic int unsigned pkt_width(input int unsigned a_sz,
                                              input int unsigned payload_sz);
        return 1 + a_sz + payload_sz;
    endfunction

    function automatic int unsigned pkt_valid_idx(input int unsigned a_sz,
                                                  input int unsigned payload_sz);
        return a_sz + payload_sz;
    endfunction

    function automatic int unsigned pkt_addr_lsb(input int unsigned payload_sz);
        return payload_sz;
    endfunction

    function automatic int unsigned pkt_payload_lsb();
        return 0;
    endfunction

endpackage

// File: rtl/leaf_inject_scheduler_rr_arbiter.sv
// rr_arbiter -- combinational round-robin pick.
//
// Grants the first set bit of req at or after index ptr, wrapping from
// num_req-1 back to 0. num_req must be a power of two so the index sum
// wraps by plain truncation.
//
// Ports:
//   req   [num_req]  request vector
//   ptr   [ptr_w]    index with highest priority this cycle
//   grant [num_req]  one-hot winner, all-zero when req is zero
module rr_arbiter #(
    parameter int num_req = 4,
    parameter int ptr_w   = $clog2(num_req)
) (
    input  logic [num_req-1:0] req,
    input  logic [ptr_w-1:0]   ptr,
    output logic [num_req-1:0] grant
);

    logic [ptr_w-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < num_req; off++) begin
            idx = ptr + ptr_w'(off);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_inject_scheduler.sv
// leaf_inject_scheduler -- shares one pi_switch leaf injection port among
// num_req local requesters.
//
// Each requester owns a one-deep holding slot. A round-robin arbiter picks
// one full slot per cycle and the winner is driven onto a registered
// packet bus. Optional token-bucket rate limiting is compiled in only when
// the macro LEAF_INJECT_RATE_LIMIT_EN is defined.
//
// Ports:
//   clk            clock, everything on posedge
//   reset          synchronous, active-high
//   req_valid_i    [num_req]             per-requester packet offer
//   req_ready_o    [num_req]             per-requester slot empty
//   req_addr_i     [num_req*a_sz]        destination leaf per requester
//   req_payload_i  [num_req*payload_sz]  payload per requester
//   stall_i        leaf port cannot accept this cycle
//   bus_o          [p_sz]                registered {valid, dest_addr, payload}
//   grant_o        [num_req]             registered one-hot of injected requester
//   inj_count_o    [16]                  saturating injected-packet count
module leaf_inject_scheduler
    import noc_pkg::*;
#(
    parameter int num_leaves  = 2,
    parameter int payload_sz  = 1,
    parameter int num_req     = 4,
    parameter int rate_period = 8,
    parameter int rate_burst  = 4,
    parameter int a_sz        = $clog2(num_leaves),
    parameter int p_sz        = 1 + a_sz + payload_sz
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [num_req-1:0]               req_valid_i,
    output logic [num_req-1:0]               req_ready_o,
    input  logic [num_req*a_sz-1:0]          req_addr_i,
    input  logic [num_req*payload_sz-1:0]    req_payload_i,
    input  logic                             stall_i,
    output logic [p_sz-1:0]                  bus_o,
    output logic [num_req-1:0]               grant_o,
    output logic [15:0]                      inj_count_o
);

    localparam int ptr_w    = $clog2(num_req);
    localparam int vld_idx  = pkt_valid_idx(a_sz, payload_sz);
    localparam int addr_lsb = pkt_addr_lsb(payload_sz);
    localparam int pay_lsb  = pkt_payload_lsb();

    logic [num_req-1:0]    hold_v;
    logic [a_sz-1:0]       hold_addr    [num_req];
    logic [payload_sz-1:0] hold_payload [num_req];
    logic [ptr_w-1:0]      ptr;

    logic [num_req-1:0]    arb_grant;
    logic [ptr_w-1:0]      win_idx;
    logic                  can_inject;
    logic                  inject;
    logic [p_sz-1:0]       pkt_next;

    logic [p_sz-1:0]       bus_q;
    logic [num_req-1:0]    grant_q;
    logic [15:0]           inj_count_q;

    rr_arbiter #(
        .num_req (num_req)
    ) u_arb (
        .req   (hold_v),
        .ptr   (ptr),
        .grant (arb_grant)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < num_req; i++) begin
            if (arb_grant[i]) begin
                win_idx = ptr_w'(i);
            end
        end
    end

    assign inject = can_inject & ~stall_i & (|hold_v);

    always_comb begin
        pkt_next                             = '0;
        pkt_next[vld_idx]                    = 1'b1;
        pkt_next[addr_lsb +: a_sz]           = hold_addr[win_idx];
        pkt_next[pay_lsb +: payload_sz]      = hold_payload[win_idx];
    end

`ifdef LEAF_INJECT_RATE_LIMIT_EN
    localparam int tok_w = $clog2(rate_burst + 1);
    localparam int rc_w  = (rate_period > 1) ? $clog2(rate_period) : 1;

    logic [tok_w-1:0] tokens;
    logic [rc_w-1:0]  refill_cnt;
    logic             refill;

    assign refill     = (refill_cnt == rc_w'(rate_period - 1));
    assign can_inject = (tokens != '0);

    // A refill and a consume in the same cycle cancel, even when the
    // bucket is full.
    always_ff @(posedge clk) begin
        if (reset) begin
            tokens     <= tok_w'(rate_burst);
            refill_cnt <= '0;
        end else begin
            refill_cnt <= refill ? '0 : refill_cnt + 1'b1;
            if (inject && !refill) begin
                tokens <= tokens - 1'b1;
            end else if (!inject && refill && (tokens != tok_w'(rate_burst))) begin
                tokens <= tokens + 1'b1;
            end
        end
    end
`else
    assign can_inject = 1'b1;
`endif

    // A slot being granted is full, so it can never be captured in the
    // same cycle; capture and release are naturally exclusive.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v      <= '0;
            ptr         <= '0;
            bus_q       <= '0;
            grant_q     <= '0;
            inj_count_q <= '0;
            for (int i = 0; i < num_req; i++) begin
                hold_addr[i]    <= '0;
                hold_payload[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_req; i++) begin
                if (req_valid_i[i] && !hold_v[i]) begin
                    hold_v[i]       <= 1'b1;
                    hold_addr[i]    <= req_addr_i[i*a_sz +: a_sz];
                    hold_payload[i] <= req_payload_i[i*payload_sz +: payload_sz];
                end else if (inject && arb_grant[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end

            if (inject) begin
                bus_q   <= pkt_next;
                grant_q <= arb_grant;
                ptr     <= win_idx + 1'b1;
                if (inj_count_q != inj_cnt_max) begin
                    inj_count_q <= inj_count_q + 16'd1;
                end
            end else begin
                bus_q   <= '0;
                grant_q <= '0;
            end
        end
    end

    assign req_ready_o = ~hold_v;
    assign bus_o       = bus_q;
    assign grant_o     = grant_q;
    assign inj_count_o = inj_count_q;

endmodule

// File: tb/tb_leaf_inject_scheduler.sv
module tb_leaf_inject_scheduler;

    localparam int NL  = 4;
    localparam int PS  = 4;
    localparam int NR  = 4;
    localparam int RP  = 8;
    localparam int RB  = 4;
    localparam int AS  = 2;
    localparam int PW  = 1 + AS + PS;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid_i;
    logic [NR-1:0]   req_ready_o;
    logic [NR*AS-1:0] req_addr_i;
    logic [NR*PS-1:0] req_payload_i;
    logic            stall_i;
    logic [PW-1:0]   bus_o;
    logic [NR-1:0]   grant_o;
    logic [15:0]     inj_count_o;

    int tests = 0;
    int fails = 0;

    leaf_inject_scheduler #(
        .num_leaves  (NL),
        .payload_sz  (PS),
        .num_req     (NR),
        .rate_period (RP),
        .rate_burst  (RB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_payload_i (req_payload_i),
        .stall_i       (stall_i),
        .bus_o         (bus_o),
        .grant_o       (grant_o),
        .inj_count_o   (inj_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot occupancy, pointer, counters, expected outputs.
    bit         model_ok = 1'b0;
    bit         mv    [NR];
    logic [1:0] maddr [NR];
    logic [3:0] mpay  [NR];
    int         mptr;
    int         mcount;
    int         mtokens;
    int         mrcnt;
    logic [PW-1:0] exp_bus;
    logic [NR-1:0] exp_grant;
    logic [NR-1:0] exp_ready;
    int  w;
    bit  ok;
    bit  refill;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) mv[i] = 1'b0;
            mptr = 0; mcount = 0; mtokens = RB; mrcnt = 0;
            exp_bus = '0; exp_grant = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            w  = -1;
            ok = !stall_i;
`ifdef LEAF_INJECT_RATE_LIMIT_EN
            ok = ok && (mtokens > 0);
`endif
            if (ok) begin
                for (int k = 0; k < NR; k++) begin
                    if (w < 0 && mv[(mptr + k) % NR]) w = (mptr + k) % NR;
                end
            end
`ifdef LEAF_INJECT_RATE_LIMIT_EN
            refill = (mrcnt == RP - 1);
            mrcnt  = refill ? 0 : mrcnt + 1;
            if (w >= 0 && !refill) mtokens = mtokens - 1;
            else if (w < 0 && refill && mtokens < RB) mtokens = mtokens + 1;
`endif
            for (int i = 0; i < NR; i++) begin
                if (req_valid_i[i] && !mv[i]) begin
                    mv[i]    = 1'b1;
                    maddr[i] = req_addr_i[i*AS +: AS];
                    mpay[i]  = req_payload_i[i*PS +: PS];
                end
            end
            if (w >= 0) begin
                exp_bus   = {1'b1, maddr[w], mpay[w]};
                exp_grant = NR'(1 << w);
                mv[w]     = 1'b0;
                mptr      = (w + 1) % NR;
                if (mcount < 65535) mcount++;
            end else begin
                exp_bus   = '0;
                exp_grant = '0;
            end
        end
        for (int i = 0; i < NR; i++) exp_ready[i] = ~mv[i];
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("bus_o",       int'(bus_o),       int'(exp_bus));
            chk("grant_o",     int'(grant_o),     int'(exp_grant));
            chk("req_ready_o", int'(req_ready_o), int'(exp_ready));
            chk("inj_count_o", int'(inj_count_o), mcount);
        end
    end

    task automatic idle_inputs();
        req_valid_i   = '0;
        req_addr_i    = '0;
        req_payload_i = '0;
        stall_i       = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset_ready", int'(req_ready_o), 15);
        chk("reset_bus",   int'(bus_o),       0);
        chk("reset_count", int'(inj_count_o), 0);

`ifndef LEAF_INJECT_RATE_LIMIT_EN
        // All four offer at once, addr i = i: grants 0..3 in order.
        reset         = 1'b0;
        req_valid_i   = 4'b1111;
        req_addr_i    = 8'b11_10_01_00;
        req_payload_i = 16'($urandom);
        @(negedge clk);
        chk("all_captured_ready", int'(req_ready_o), 0);
        req_valid_i = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_grant", int'(grant_o), 1 << k);
            chk("seq_valid", int'(bus_o[6]), 1);
            chk("seq_addr",  int'(bus_o[5:4]), k);
        end
        chk("seq_count", int'(inj_count_o), 4);

        // Move ptr to 2, then slots 1 and 3 full: 3 first, then 1.
        req_valid_i = 4'b0010;
        @(negedge clk);
        req_valid_i = '0;
        @(negedge clk);
        chk("ptr_setup_grant", int'(grant_o), 2);
        req_valid_i = 4'b1010;
        stall_i     = 1'b1;
        @(negedge clk);
        chk("stalled_grant", int'(grant_o), 0);
        req_valid_i = '0;
        stall_i     = 1'b0;
        @(negedge clk);
        chk("rr_first", int'(grant_o), 8);
        @(negedge clk);
        chk("rr_second", int'(grant_o), 2);
        req_valid_i = 4'b1111;
        stall_i     = 1'b1;
        @(negedge clk);
        req_valid_i = '0;
        stall_i     = 1'b0;
        @(negedge clk);
        chk("ptr_at_2", int'(grant_o), 4);
        repeat (3) @(negedge clk);

        // Stall with slot 0 full for 5 cycles.
        req_valid_i = 4'b0001;
        stall_i     = 1'b1;
        @(negedge clk);
        req_valid_i = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_bus",    int'(bus_o), 0);
            chk("stall_ready0", int'(req_ready_o[0]), 0);
        end
        stall_i = 1'b0;
        @(negedge clk);
        chk("unstall_grant", int'(grant_o), 1);

        // Reset while slot 2 full and bus valid.
        req_valid_i = 4'b0110;
        @(negedge clk);
        req_valid_i = '0;
        @(negedge clk);
        chk("pre_reset_grant",  int'(grant_o), 2);
        chk("pre_reset_ready2", int'(req_ready_o[2]), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_bus",   int'(bus_o), 0);
        chk("mid_reset_grant", int'(grant_o), 0);
        chk("mid_reset_ready", int'(req_ready_o), 15);
        chk("mid_reset_count", int'(inj_count_o), 0);

        // Saturate the injection counter.
        reset         = 1'b0;
        req_valid_i   = 4'b1111;
        req_addr_i    = 8'($urandom);
        req_payload_i = 16'($urandom);
        repeat (65545) @(negedge clk);
        chk("count_saturated", int'(inj_count_o), 65535);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
`else
        // All requesters saturating for 40 cycles: 4 back-to-back, then 1 per 8.
        reset       = 1'b0;
        req_valid_i = 4'b1111;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (grant_o != 0) seen++;
                if (k >= 1 && k <= 4) chk("burst_grant_valid", int'(bus_o[6]), 1);
                if (k >= 5 && k <= 7) chk("drained_bus", int'(bus_o), 0);
            end
            chk("rate_total", seen, 8);
            chk("rate_count", int'(inj_count_o), 8);
        end
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
`endif

        // Randomized traffic with occasional stall and reset.
        reset = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            req_valid_i   = 4'($urandom);
            req_addr_i    = 8'($urandom);
            req_payload_i = 16'($urandom);
            stall_i       = ($urandom_range(0, 4) == 0);
            reset         = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        idle_inputs();
        reset = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
